// File: rtl/alu_muldiv_ctrl.sv
`default_nettype none
//==============================================================================
// Module : alu_muldiv_ctrl
// Desc   : MIPS EX-stage ALU control decode plus iterative mul/div with HI/LO.
//          Optional macro MULDIV_EARLY_EXIT_EN: multiply ends once the
//          remaining multiplier bits are all zero.
// Rev    : 1.0  initial release
//==============================================================================
module alu_muldiv_ctrl #(
   parameter int NB_DATA = 32,
   parameter int FBITS   = 6,
   parameter int OPBITS  = 3,
   parameter int CTRBITS = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [OPBITS-1:0]  ALU_op,
   input  logic [FBITS-1:0]   i_funct,
   input  logic [NB_DATA-1:0] i_rs,
   input  logic [NB_DATA-1:0] i_rt,
   output logic [CTRBITS-1:0] ALU_control,
   output logic               o_busy,
   output logic               o_stall,
   output logic               o_done,
   output logic [NB_DATA-1:0] o_hilo,
   output logic               o_hilo_sel
);

   localparam int CW = $clog2(NB_DATA + 1);

   localparam logic [FBITS-1:0] F_MFHI  = 6'b010000;
   localparam logic [FBITS-1:0] F_MTHI  = 6'b010001;
   localparam logic [FBITS-1:0] F_MFLO  = 6'b010010;
   localparam logic [FBITS-1:0] F_MTLO  = 6'b010011;
   localparam logic [FBITS-1:0] F_MULT  = 6'b011000;
   localparam logic [FBITS-1:0] F_MULTU = 6'b011001;
   localparam logic [FBITS-1:0] F_DIV   = 6'b011010;
   localparam logic [FBITS-1:0] F_DIVU  = 6'b011011;

`ifdef MULDIV_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   state_t               state;
   logic                 busy;
   logic                 done;
   logic                 is_div;
   logic                 div_zero;
   logic                 neg_res;
   logic                 neg_rem;
   logic [CW-1:0]        count;
   logic [NB_DATA-1:0]   hi;
   logic [NB_DATA-1:0]   lo;
   logic [NB_DATA-1:0]   mplier;
   logic [NB_DATA-1:0]   quot;
   logic [NB_DATA-1:0]   divisor;
   logic [NB_DATA-1:0]   rem;
   logic [NB_DATA-1:0]   dividend_raw;
   logic [2*NB_DATA-1:0] mcand;
   logic [2*NB_DATA-1:0] acc;

   logic                 md_op;
   logic                 op_signed;
   logic                 rs_neg;
   logic                 rt_neg;
   logic [NB_DATA-1:0]   rs_mag;
   logic [NB_DATA-1:0]   rt_mag;
   logic [NB_DATA:0]     shifted;
   logic [NB_DATA+1:0]   diff;

   assign md_op = i_valid && (ALU_op == '0) &&
                  (i_funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                   F_MULT, F_MULTU, F_DIV, F_DIVU});

   assign op_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
   assign rs_neg    = op_signed & i_rs[NB_DATA-1];
   assign rt_neg    = op_signed & i_rt[NB_DATA-1];
   assign rs_mag    = rs_neg ? -i_rs : i_rs;
   assign rt_mag    = rt_neg ? -i_rt : i_rt;

   // Restoring-divide trial subtraction; extra top bit catches the borrow.
   assign shifted = {rem, quot[NB_DATA-1]};
   assign diff    = {1'b0, shifted} - {2'b00, divisor};

   assign o_busy     = busy;
   assign o_done     = done;
   assign o_stall    = busy & md_op;
   assign o_hilo_sel = md_op && ((i_funct == F_MFHI) || (i_funct == F_MFLO));
   assign o_hilo     = !md_op            ? '0 :
                       (i_funct == F_MFHI) ? hi :
                       (i_funct == F_MFLO) ? lo : '0;

   always_comb begin
      ALU_control = '0;
      case (ALU_op)
         3'b000: begin
            case (i_funct)
               6'b100000, 6'b100001,
               6'b001001, 6'b001000: ALU_control = 4'b0000;
               6'b100100:            ALU_control = 4'b0001;
               6'b100111:            ALU_control = 4'b0010;
               6'b100101:            ALU_control = 4'b0011;
               6'b000000:            ALU_control = 4'b0100;
               6'b000010:            ALU_control = 4'b0101;
               6'b000011:            ALU_control = 4'b0110;
               6'b100010, 6'b100011: ALU_control = 4'b0111;
               6'b100110:            ALU_control = 4'b1000;
               6'b000111:            ALU_control = 4'b1001;
               6'b000110:            ALU_control = 4'b1010;
               6'b000100:            ALU_control = 4'b1011;
               6'b101010:            ALU_control = 4'b1100;
               default:              ALU_control = 4'b0000;
            endcase
         end
         3'b001:  ALU_control = 4'b0000;
         3'b010:  ALU_control = 4'b0001;
         3'b011:  ALU_control = 4'b0011;
         3'b100:  ALU_control = 4'b1000;
         3'b101:  ALU_control = 4'b1100;
         3'b110:  ALU_control = 4'b0111;
         3'b111:  ALU_control = 4'b1101;
         default: ALU_control = 4'b0000;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         is_div       <= 1'b0;
         div_zero     <= 1'b0;
         neg_res      <= 1'b0;
         neg_rem      <= 1'b0;
         count        <= '0;
         hi           <= '0;
         lo           <= '0;
         mplier       <= '0;
         quot         <= '0;
         divisor      <= '0;
         rem          <= '0;
         dividend_raw <= '0;
         mcand        <= '0;
         acc          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (md_op) begin
                  case (i_funct)
                     F_MTHI: hi <= i_rs;
                     F_MTLO: lo <= i_rs;
                     F_MULT, F_MULTU: begin
                        mcand   <= {{NB_DATA{1'b0}}, rs_mag};
                        mplier  <= rt_mag;
                        acc     <= '0;
                        neg_res <= rs_neg ^ rt_neg;
                        is_div  <= 1'b0;
                        count   <= CW'(NB_DATA);
                        busy    <= 1'b1;
                        state   <= (EARLY_EXIT && (rt_mag == '0)) ? ST_FIX : ST_MUL;
                     end
                     F_DIV, F_DIVU: begin
                        quot         <= rs_mag;
                        divisor      <= rt_mag;
                        rem          <= '0;
                        neg_res      <= rs_neg ^ rt_neg;
                        neg_rem      <= rs_neg;
                        div_zero     <= (i_rt == '0);
                        dividend_raw <= i_rs;
                        is_div       <= 1'b1;
                        count        <= CW'(NB_DATA);
                        busy         <= 1'b1;
                        state        <= ST_DIV;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - CW'(1);
               if ((count == CW'(1)) || (EARLY_EXIT && (mplier[NB_DATA-1:1] == '0)))
                  state <= ST_FIX;
            end
            ST_DIV: begin
               if (!diff[NB_DATA+1]) begin
                  rem  <= diff[NB_DATA-1:0];
                  quot <= {quot[NB_DATA-2:0], 1'b1};
               end else begin
                  rem  <= shifted[NB_DATA-1:0];
                  quot <= {quot[NB_DATA-2:0], 1'b0};
               end
               count <= count - CW'(1);
               if (count == CW'(1))
                  state <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div) begin
                  if (div_zero) begin
                     hi <= dividend_raw;
                     lo <= '1;
                  end else begin
                     lo <= neg_res ? -quot : quot;
                     hi <= neg_rem ? -rem : rem;
                  end
               end else begin
                  {hi, lo} <= neg_res ? -acc : acc;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_alu_muldiv_ctrl
// Desc   : Directed self-checking bench for alu_muldiv_ctrl.
// Rev    : 1.0  initial release
//==============================================================================
module tb_alu_muldiv_ctrl;

   localparam int NB = 32;

`ifdef MULDIV_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic [2:0]    alu_op;
   logic [5:0]    funct;
   logic [NB-1:0] rs;
   logic [NB-1:0] rt;
   logic [3:0]    alu_control;
   logic          busy;
   logic          stall;
   logic          done;
   logic [NB-1:0] hilo;
   logic          hilo_sel;

   int errors = 0;
   int checks = 0;

   alu_muldiv_ctrl dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_valid     (valid),
      .ALU_op      (alu_op),
      .i_funct     (funct),
      .i_rs        (rs),
      .i_rt        (rt),
      .ALU_control (alu_control),
      .o_busy      (busy),
      .o_stall     (stall),
      .o_done      (done),
      .o_hilo      (hilo),
      .o_hilo_sel  (hilo_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                        input logic [NB-1:0] a, input logic [NB-1:0] b);
      valid  = v;
      alu_op = op;
      funct  = f;
      rs     = a;
      rt     = b;
   endtask

   // Expected busy length of a multiply given the multiplier magnitude.
   function automatic int mul_lat(input logic [NB-1:0] m);
      int idx = -1;
      for (int i = 0; i < NB; i++)
         if (m[i]) idx = i;
      if (!EARLY) return NB + 1;
      return (m == '0) ? 1 : idx + 2;
   endfunction

   task automatic run_md(input logic [5:0] f, input logic [NB-1:0] a, input logic [NB-1:0] b,
                         output int cycles, output logic done_seen);
      drive(1'b1, 3'b000, f, a, b);
      @(posedge clk); #1;
      drive(1'b0, 3'b000, 6'b0, '0, '0);
      cycles = 0;
      while (busy && cycles < 200) begin
         cycles++;
         @(posedge clk); #1;
      end
      done_seen = done;
   endtask

   task automatic read_hilo(input string tag, input logic [5:0] f, input logic [NB-1:0] exp);
      drive(1'b1, 3'b000, f, '0, '0);
      #1;
      check({tag, "_val"}, 64'(hilo), 64'(exp));
      check({tag, "_sel"}, 64'(hilo_sel), 64'd1);
      drive(1'b0, 3'b000, 6'b0, '0, '0);
   endtask

   task automatic md_case(input string tag, input logic [5:0] f, input logic [NB-1:0] a,
                          input logic [NB-1:0] b, input int lat,
                          input logic [NB-1:0] exp_hi, input logic [NB-1:0] exp_lo);
      int   cyc;
      logic dn;
      run_md(f, a, b, cyc, dn);
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      check({tag, "_done"}, 64'(dn), 64'd1);
      read_hilo({tag, "_hi"}, F_MFHI, exp_hi);
      read_hilo({tag, "_lo"}, F_MFLO, exp_lo);
   endtask

   initial begin : main
      int   k;
      logic stall_ok;

      rst = 1'b1;
      drive(1'b0, 3'b000, 6'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      read_hilo("rst_hi", F_MFHI, '0);
      read_hilo("rst_lo", F_MFLO, '0);

      // ALU_control decode
      drive(1'b1, 3'b000, 6'b100010, '0, '0); #1; check("dec_sub",  64'(alu_control), 64'b0111);
      drive(1'b1, 3'b111, 6'b000000, '0, '0); #1; check("dec_lui",  64'(alu_control), 64'b1101);
      drive(1'b1, 3'b000, F_MULT,    '0, '0); #1; check("dec_mult", 64'(alu_control), 64'b0000);
      drive(1'b1, 3'b000, 6'b100111, '0, '0); #1; check("dec_nor",  64'(alu_control), 64'b0010);
      drive(1'b1, 3'b000, 6'b000111, '0, '0); #1; check("dec_srav", 64'(alu_control), 64'b1001);
      drive(1'b1, 3'b101, 6'b000000, '0, '0); #1; check("dec_slti", 64'(alu_control), 64'b1100);
      drive(1'b1, 3'b000, 6'b101010, '0, '0); #1; check("dec_slt",  64'(alu_control), 64'b1100);
      drive(1'b0, 3'b000, 6'b0, '0, '0);
      @(posedge clk); #1;

      md_case("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'd7, mul_lat(32'd7),
              32'hFFFF_FFFF, 32'hFFFF_FFEB);
      md_case("divu",      F_DIVU,  32'd100, 32'd7, NB + 1, 32'd2, 32'd14);
      md_case("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'd2, NB + 1,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
      md_case("divu_zero", F_DIVU,  32'd5, 32'd0, NB + 1, 32'd5, 32'hFFFF_FFFF);
      md_case("div_min",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, NB + 1,
              32'd0, 32'h8000_0000);
      md_case("mult_min",  F_MULT,  32'h8000_0000, 32'h8000_0000, mul_lat(32'h8000_0000),
              32'h4000_0000, 32'd0);
      md_case("multu_9x3", F_MULTU, 32'd9, 32'd3, mul_lat(32'd3), 32'd0, 32'd27);
      md_case("multu_big", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_lat(32'hFFFF_FFFF),
              32'hFFFF_FFFE, 32'd1);

      // Stall handshake: ADD on busy cycle 3, MFHI from busy cycle 5 until done
      drive(1'b1, 3'b000, F_DIV, 32'd100, 32'd7);
      @(posedge clk); #1;
      k = 1;
      stall_ok = 1'b1;
      while (busy && k < 200) begin
         if (k == 3) begin
            drive(1'b1, 3'b000, 6'b100000, 32'd1, 32'd2);
            #1;
            check("add_nostall", 64'(stall), 64'd0);
            check("add_ctl", 64'(alu_control), 64'b0000);
         end else if (k >= 5) begin
            drive(1'b1, 3'b000, F_MFHI, '0, '0);
            #1;
            if (!stall) stall_ok = 1'b0;
         end else begin
            drive(1'b0, 3'b000, 6'b0, '0, '0);
            #1;
         end
         @(posedge clk); #1;
         k++;
      end
      check("stall_busy_len", 64'(k - 1), 64'(NB + 1));
      check("stall_held", 64'(stall_ok), 64'd1);
      check("stall_release", 64'(stall), 64'd0);
      check("stall_done", 64'(done), 64'd1);
      check("stall_new_hi", 64'(hilo), 64'd2);
      drive(1'b0, 3'b000, 6'b0, '0, '0);
      @(posedge clk); #1;
      check("done_pulse", 64'(done), 64'd0);

      // MTLO / MTHI
      drive(1'b1, 3'b000, F_MTLO, 32'h0000_1234, '0);
      @(posedge clk); #1;
      check("mtlo_busy", 64'(busy), 64'd0);
      read_hilo("mtlo", F_MFLO, 32'h0000_1234);
      drive(1'b1, 3'b000, F_MTHI, 32'hCAFE_0001, '0);
      @(posedge clk); #1;
      read_hilo("mthi", F_MFHI, 32'hCAFE_0001);

      // Invalid instructions do nothing
      drive(1'b0, 3'b000, F_MULT, 32'd3, 32'd4);
      @(posedge clk); #1;
      check("inval_mult_busy", 64'(busy), 64'd0);
      drive(1'b0, 3'b000, F_MTLO, 32'hDEAD_BEEF, '0);
      @(posedge clk); #1;
      check("inval_mtlo_busy", 64'(busy), 64'd0);
      read_hilo("inval_lo", F_MFLO, 32'h0000_1234);
      drive(1'b0, 3'b000, F_MFHI, '0, '0);
      #1;
      check("inval_sel", 64'(hilo_sel), 64'd0);
      check("inval_hilo", 64'(hilo), 64'd0);

      // Reset on busy cycle 10 of a divide
      drive(1'b1, 3'b000, F_DIVU, 32'd100, 32'd7);
      @(posedge clk); #1;
      drive(1'b0, 3'b000, 6'b0, '0, '0);
      for (int i = 1; i < 10; i++) begin
         @(posedge clk); #1;
      end
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      check("abort_done2", 64'(done), 64'd0);
      read_hilo("abort_hi", F_MFHI, '0);
      read_hilo("abort_lo", F_MFLO, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
